// File: rtl/clock_time_set.sv
// Timekeeping and time-set controller: synchronises debounced mode/inc buttons, runs a 1 Hz
// prescaled 24-hour HH:MM:SS counter and lets the user set hours and minutes.
module clock_time_set #(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       mode_pb,
  input  logic       inc_pb,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetHr  = 2'b01,
    StSetMin = 2'b10
  } state_e;

  // Button front end: 2-flop synchroniser plus a previous-value flop per button
  logic mode_s1_q, mode_s2_q, mode_prev_q;
  logic inc_s1_q, inc_s2_q, inc_prev_q;
  logic mode_evt, inc_evt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q   <= 1'b0;
      mode_s2_q   <= 1'b0;
      mode_prev_q <= 1'b0;
      inc_s1_q    <= 1'b0;
      inc_s2_q    <= 1'b0;
      inc_prev_q  <= 1'b0;
    end else begin
      mode_s1_q   <= mode_pb;
      mode_s2_q   <= mode_s1_q;
      mode_prev_q <= mode_s2_q;
      inc_s1_q    <= inc_pb;
      inc_s2_q    <= inc_s1_q;
      inc_prev_q  <= inc_s2_q;
    end
  end

  assign mode_evt = mode_s2_q & ~mode_prev_q;
  assign inc_evt  = inc_s2_q & ~inc_prev_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      hours_q, hours_d;
  logic [5:0]      minutes_q, minutes_d;
  logic [5:0]      seconds_q, seconds_d;
  logic            blink_q, blink_d;
  logic            sec_tick_q, sec_tick_d;
  logic            tick;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    state_d    = state_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    sec_tick_d = 1'b0;

    unique case (state_q)
      StRun: begin
        // A mode event wins over a coincident tick; the tick is dropped
        if (mode_evt) begin
          state_d   = StSetHr;
          seconds_d = '0;
        end else if (tick) begin
          sec_tick_d = 1'b1;
          if (seconds_q == 6'd59) begin
            seconds_d = '0;
            if (minutes_q == 6'd59) begin
              minutes_d = '0;
              hours_d   = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end
      end
      StSetHr: begin
        if (mode_evt) begin
          state_d = StSetMin;
        end else if (inc_evt) begin
          hours_d = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
        end
      end
      StSetMin: begin
        if (mode_evt) begin
          state_d = StRun;
        end else if (inc_evt) begin
          minutes_d = (minutes_q == 6'd59) ? '0 : minutes_q + 6'd1;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Restart the second on every mode change so RUN's first tick lands a full period later
    if ((state_d != state_q) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    // Registered blink tracks the prescaler value it is registered alongside
    blink_d = (state_d != StRun) && (cnt_d < CntHalf);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      hours_q    <= '0;
      minutes_q  <= '0;
      seconds_q  <= '0;
      blink_q    <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      blink_q    <= blink_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign hours    = hours_q;
  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign mode     = state_q;
  assign blink    = blink_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: doc/clock_time_set.md
# clock_time_set

Timekeeping and time-set controller for the digital clock, sitting directly downstream of the push-button debouncers. It takes the debounced mode and increment button levels, which are slow-clock-domain pulses lasting many `clk_in` cycles. It synchronises them and edge-detects them to one-cycle events. A three-state FSM (run / set hours / set minutes) then drives a 24-hour HH:MM:SS counter advanced by an internal 1 Hz prescaler. Its outputs feed the display/decoder stage.

## Interface
- `CLK_DIV`, default 100_000_000: `clk_in` cycles per second tick. Legal values are ≥ 4 and even. Simulation uses 10.
- `clk_in`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `mode_pb`  input  1  debounced mode button level, asynchronous to `clk_in`.
- `inc_pb`  input  1  debounced increment button level, asynchronous to `clk_in`.
- `hours`  output  5  hours, 0–23.
- `minutes`  output  6  minutes, 0–59.
- `seconds`  output  6  seconds, 0–59.
- `mode`  output  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN. Value 11 is never produced.
- `blink`  output  1  display blink enable for the field being set.
- `sec_tick`  output  1  one-cycle pulse in the cycle `seconds` advances.

## Operation
- **Button front end**
  - Each of `mode_pb` and `inc_pb` passes through a 2-flop synchroniser and then a previous-value flop. All three flops reset to 0.
  - An event is `sync2 & ~prev`: exactly one cycle per rising edge, however long the level is held.
  - A level already high when reset releases produces an event once it has propagated.
- **Prescaler**
  - `cnt` counts 0..CLK_DIV-1 and wraps.
  - Internal tick = `cnt == CLK_DIV-1`.
  - `cnt` is forced to 0 on every `mode` state change.
- **FSM**
  - Each mode event advances the state: RUN→SET_HR→SET_MIN→RUN.
  - RUN→SET_HR: `seconds` cleared to 0.
  - RUN: each tick increments `seconds`, with carries. 59 s → 0 carries into `minutes`; 59 min → 0 carries into `hours`; 23 → 0. So 23:59:59 → 00:00:00. `sec_tick`=1 in the cycle `seconds` updates.
  - SET_HR: each inc event sets `hours` = (`hours`+1) mod 24. Ticks are ignored and `seconds` is held.
  - SET_MIN: each inc event sets `minutes` = (`minutes`+1) mod 60, with no carry into `hours`. Ticks are ignored.
  - RUN ignores inc events.
- **Simultaneous events**
  - Mode and inc events in the same cycle: mode wins and inc is discarded.
  - Mode event coinciding with a tick in RUN: the transition to SET_HR takes effect, `seconds` clears, and the tick is discarded.
- **blink**
  - RUN: 0.
  - SET_HR / SET_MIN: 1 while `cnt` < CLK_DIV/2, else 0. This gives a 1 Hz, 50 % square wave that starts high.
- **Reset**
  - Assertion at any time, including mid-increment or mid-set, immediately forces: `hours`=`minutes`=`seconds`=0, `mode`=00, `blink`=0, `sec_tick`=0, `cnt`=0, and all synchroniser flops = 0.

## Timing
- Input-to-output latency:
  - A button rising edge sampled at `clk_in` edge k makes the event active in the cycle after edge k+1.
  - `mode`, `hours` and `minutes` therefore update at edge k+2.
  - The input must stay high across at least 2 edges to be seen. Debounced pulses always do.
- RUN seconds cadence:
  - The first tick after entering RUN comes exactly CLK_DIV cycles after the transition edge.
  - Afterwards there is one tick every CLK_DIV cycles.
- `sec_tick` is registered and high for exactly 1 cycle, in the same cycle the new `seconds` value is visible.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- After `rst_n` deasserts, the first tick comes CLK_DIV cycles after the first active edge.

## Test plan
- **Reset mid-count:** run to 00:00:37, assert `rst_n`=0 between edges. All outputs are 0 and `mode`=00 immediately, without waiting for a clock edge. After release, `seconds` reaches 1 after exactly 10 cycles (CLK_DIV=10).
- **Full rollover:** preload via set mode to 23:59, return to RUN, run 60 ticks. Expect 23:59:59 → 00:00:00 with `sec_tick` pulsing exactly 60 times.
- **Set sequence:**
  - One mode pulse gives `mode`=01, `seconds`=0 and `blink` toggling every 5 cycles.
  - 25 inc pulses take `hours` from 0 to 1, wrapping at 23→0.
  - A mode pulse gives `mode`=10; 61 inc pulses give `minutes`=1 with `hours` unchanged.
  - A mode pulse gives `mode`=00 and `blink`=0.
- **Long level:** hold `inc_pb` high 500 cycles in SET_HR. `hours` increments exactly once, 3 edges after the rise.
- **Simultaneous events:** raise `mode_pb` and `inc_pb` together in SET_HR. `mode` goes to 10 and `hours` is unchanged.
- **Ignored events:** inc pulses in RUN leave the time unchanged. Ticks in SET_MIN leave `seconds`=0 and `sec_tick`=0.
